wishbone_arbiter_2m4s: RTL and testbench
========================================

# wishbone_arbiter_2m4s

Shared-bus arbiter and address decoder sitting directly downstream of the two CPU-side `wishbone_bus_if` masters: the data bus (M0) and the instruction bus (M1). It grants one master at a time with round-robin fairness. It routes the granted cycle to one of four slaves by address. It terminates hung or unmapped accesses itself, so a master's `o_stallreq` can never hang forever.

## Interface
- `TIMEOUT`, 256: cycles a granted transfer may wait for slave ack before forced termination; legal range 2..65535.
- `ERR_DATA`, 32'h0: read data returned on an error/timeout termination.
- `i_clk` input 1: clock.
- `i_rst_n` input 1: reset, asynchronous, active-low.
- `i_m_addr` input [1:0][31:0]: master address (index 0 = dbus, 1 = ibus).
- `i_m_data` input [1:0][31:0]: master write data.
- `i_m_we`, `i_m_stb`, `i_m_cyc` input [1:0]: per-master write enable, strobe, cycle.
- `i_m_sel` input [1:0][3:0]: byte selects.
- `o_m_data` output [1:0][31:0]: read data to master.
- `o_m_ack` output [1:0]: ack to master.
- `o_s_addr` output [3:0][31:0], `o_s_data` output [3:0][31:0], `o_s_we`/`o_s_stb`/`o_s_cyc` output [3:0], `o_s_sel` output [3:0][3:0]: per-slave request.
- `i_s_data` input [3:0][31:0], `i_s_ack` input [3:0]: per-slave response.
- `o_bus_err` output 1: one-cycle error pulse.
- `o_err_code` output 2: 01 unmapped, 10 timeout, held until next error.
- `o_err_addr` output 32: address of last errored transfer.

## Operation
- State machine `arb_state_t`: S_IDLE, S_GNT0, S_GNT1.
- **S_IDLE.** A request is `cyc & stb`.
  - Only one master requesting: grant it.
  - Both requesting: grant the master not served last. The `last` flag resets to 1, so M0 wins the first tie.
  - Grant takes effect next cycle.
- **S_GNTx.** The granted master's signals are routed combinationally to slave `addr[29:28]`. Only that slave sees `stb`/`cyc` = 1; all other slave outputs are 0. Non-granted master: `ack` = 0, `data` = 0.
- **Decode.**
  - `addr[31:30] != 0` is unmapped. No slave is strobed. Internal ack fires in the first grant cycle with `ERR_DATA`, code 01.
- **Termination.** The transfer ends on whichever comes first:
  - Selected slave ack: forwarded to the master in the same cycle, with `i_s_data` if `we` = 0, else 0.
  - Unmapped internal ack.
  - Timeout: the 16-bit counter reaches `TIMEOUT-1` in grant with no ack. One forced ack with `ERR_DATA`, code 10; the slave `stb`/`cyc` drops in that cycle.
  - Abort: the granted master deasserts `cyc` (flush). No ack is generated.
- Any termination: next state S_IDLE; `last` <= granted index; counter cleared.
- Slave ack arriving while `stb` = 0 (late ack after timeout) is ignored.
- Error termination: `o_bus_err` pulses the cycle after the forced ack; `o_err_addr`/`o_err_code` update on the same edge.

## Timing
- Reset values: state S_IDLE, `last` = 1, counter 0; all `o_s_*` and `o_m_*` 0; `o_bus_err` 0, `o_err_code` 0, `o_err_addr` 0.
- Request at cycle T (in idle) -> slave `stb` at T+1.
- Zero-wait slave: ack at T+1, returned to master at T+1. The master's `stb` must drop by T+2; the arbiter is already in S_IDLE at T+2.
- Back-to-back: minimum 2 cycles per transfer per arbitration (1 arbitration + ≥1 data).
- Timeout: the forced ack is at grant cycle `TIMEOUT` (counter 0 on first grant cycle).
- Reset mid-transfer: all outputs 0 immediately (asynchronous), with no ack generated.
- Simultaneous slave ack and timeout in the same cycle: slave ack wins, no error.

## Structure
- Package `wb_pkg`:
  - `WB_AW` = 32, `WB_DW` = 32, `WB_SELW` = 4.
  - `N_MST` = 2, `N_SLV` = 4.
  - `SLV_IDX_HI`/`LO` = 29/28.
  - `arb_state_t`, `wb_err_e` (`ERR_NONE`, `ERR_UNMAPPED`, `ERR_TIMEOUT`).
- Sub-module `wb_addr_decode`: combinational; addr -> one-hot slave select [3:0] plus `unmapped` flag.

## Test plan
- M0 reads 0x1000_0040, slave1 acks the first cycle with 0xCAFE_0001 -> `o_s_stb[1]` high 1 cycle, `o_m_ack[0]` with 0xCAFE_0001, no other slave strobed.
- M0 and M1 request together, repeatedly -> grants alternate M0, M1, M0, M1; M1 never starves.
- M1 reads 0xC000_0000 -> `o_m_ack[1]` in first grant cycle with data 0; `o_bus_err` pulse next cycle; `o_err_code` = 01, `o_err_addr` = 0xC000_0000.
- `TIMEOUT` = 8, slave2 never acks -> forced ack exactly 8 cycles after grant; `o_err_code` = 10; late slave ack at cycle 10 ignored.
- M0 drops `cyc` after 3 grant cycles without ack -> no ack, S_IDLE next cycle, pending M1 granted the following cycle.
- Assert `i_rst_n` low mid-write to slave3 -> all `o_s_stb`/`o_m_ack` 0 immediately; after release, M0 wins the first tie.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared Wishbone widths, the arbiter state encoding and the error codes used by
// the 2-master / 4-slave arbiter.
package wb_pkg;

    localparam int WB_AW      = 32;
    localparam int WB_DW      = 32;
    localparam int WB_SELW    = 4;
    localparam int N_MST      = 2;
    localparam int N_SLV      = 4;
    localparam int SLV_IDX_HI = 29;
    localparam int SLV_IDX_LO = 28;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_GNT0 = 2'b01,
        S_GNT1 = 2'b10
    } arb_state_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_UNMAPPED = 2'b01,
        ERR_TIMEOUT  = 2'b10
    } wb_err_e;

endpackage

// File: rtl/wb_addr_decode.sv
// Address decoder: bits [31:30] must be zero, bits [29:28] select one of four slaves.
module wb_addr_decode
    import wb_pkg::*;
(
    input  logic [WB_AW-1:0] addr_i,
    output logic [N_SLV-1:0] slv_sel_o,
    output logic             unmapped_o
);

    always_comb begin
        unmapped_o = |addr_i[WB_AW-1:SLV_IDX_HI+1];
        slv_sel_o  = '0;
        if (!unmapped_o) begin
            slv_sel_o[addr_i[SLV_IDX_HI:SLV_IDX_LO]] = 1'b1;
        end
    end

endmodule

// File: rtl/wishbone_arbiter_2m4s.sv
// Round-robin arbiter for the dbus (M0) and ibus (M1) onto four Wishbone slaves,
// with internal termination of unmapped and timed-out accesses.
//
//   state  | meaning
//   S_IDLE | no grant; arbitrate between pending requests
//   S_GNT0 | M0 owns the bus until ack, timeout or cyc drop
//   S_GNT1 | M1 owns the bus until ack, timeout or cyc drop
module wishbone_arbiter_2m4s
    import wb_pkg::*;
#(
    parameter int unsigned      TIMEOUT  = 256,
    parameter logic [WB_DW-1:0] ERR_DATA = '0
) (
    input  logic                                i_clk,
    input  logic                                i_rst_n,
    input  logic [N_MST-1:0][WB_AW-1:0]         i_m_addr,
    input  logic [N_MST-1:0][WB_DW-1:0]         i_m_data,
    input  logic [N_MST-1:0]                    i_m_we,
    input  logic [N_MST-1:0]                    i_m_stb,
    input  logic [N_MST-1:0]                    i_m_cyc,
    input  logic [N_MST-1:0][WB_SELW-1:0]       i_m_sel,
    output logic [N_MST-1:0][WB_DW-1:0]         o_m_data,
    output logic [N_MST-1:0]                    o_m_ack,
    output logic [N_SLV-1:0][WB_AW-1:0]         o_s_addr,
    output logic [N_SLV-1:0][WB_DW-1:0]         o_s_data,
    output logic [N_SLV-1:0]                    o_s_we,
    output logic [N_SLV-1:0]                    o_s_stb,
    output logic [N_SLV-1:0]                    o_s_cyc,
    output logic [N_SLV-1:0][WB_SELW-1:0]       o_s_sel,
    input  logic [N_SLV-1:0][WB_DW-1:0]         i_s_data,
    input  logic [N_SLV-1:0]                    i_s_ack,
    output logic                                o_bus_err,
    output logic [1:0]                          o_err_code,
    output logic [WB_AW-1:0]                    o_err_addr
);

    arb_state_t       state_q;
    logic             last_q;
    logic [15:0]      cnt_q;
    logic             bus_err_q;
    wb_err_e          err_code_q;
    logic [WB_AW-1:0] err_addr_q;

    logic             granted;
    logic             gnt_idx;
    logic [WB_AW-1:0] g_addr;
    logic             g_cyc;
    logic             g_req;
    logic [N_SLV-1:0] slv_sel;
    logic             unmapped;
    logic             to_hit;
    logic             slv_ack;
    logic             unm_ack;
    logic             to_ack;
    logic             term_ack;
    logic             abort;
    logic             err_fire;
    logic [WB_DW-1:0] sel_data;
    logic [N_MST-1:0] req;

    assign granted = (state_q == S_GNT0) || (state_q == S_GNT1);
    assign gnt_idx = (state_q == S_GNT1);
    assign g_addr  = i_m_addr[gnt_idx];
    assign g_cyc   = granted & i_m_cyc[gnt_idx];
    assign g_req   = g_cyc & i_m_stb[gnt_idx];
    assign req     = i_m_cyc & i_m_stb;

    wb_addr_decode u_dec (
        .addr_i     (g_addr),
        .slv_sel_o  (slv_sel),
        .unmapped_o (unmapped)
    );

    // Ack is qualified by the grant, not by the outgoing stb, so a slave ack
    // landing in the timeout cycle still beats the forced termination.
    assign to_hit   = granted && (cnt_q == 16'(TIMEOUT - 1));
    assign slv_ack  = g_req & ~unmapped & |(i_s_ack & slv_sel);
    assign unm_ack  = g_req & unmapped;
    assign to_ack   = g_cyc & ~unmapped & to_hit & ~slv_ack;
    assign term_ack = slv_ack | unm_ack | to_ack;
    assign abort    = granted & ~i_m_cyc[gnt_idx];
    assign err_fire = unm_ack | to_ack;

    always_comb begin
        sel_data = '0;
        for (int s = 0; s < N_SLV; s++) begin
            if (slv_sel[s]) sel_data = sel_data | i_s_data[s];
        end
    end

    always_comb begin
        o_s_addr = '0;
        o_s_data = '0;
        o_s_we   = '0;
        o_s_stb  = '0;
        o_s_cyc  = '0;
        o_s_sel  = '0;
        for (int s = 0; s < N_SLV; s++) begin
            if (g_cyc && !unmapped && slv_sel[s]) begin
                o_s_addr[s] = g_addr;
                o_s_data[s] = i_m_data[gnt_idx];
                o_s_we[s]   = i_m_we[gnt_idx];
                o_s_sel[s]  = i_m_sel[gnt_idx];
                o_s_stb[s]  = i_m_stb[gnt_idx] & ~to_hit;
                o_s_cyc[s]  = ~to_hit;
            end
        end
    end

    always_comb begin
        o_m_ack  = '0;
        o_m_data = '0;
        if (term_ack) begin
            o_m_ack[gnt_idx] = 1'b1;
            if (slv_ack) begin
                o_m_data[gnt_idx] = i_m_we[gnt_idx] ? '0 : sel_data;
            end else begin
                o_m_data[gnt_idx] = ERR_DATA;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            last_q     <= 1'b1;
            cnt_q      <= '0;
            bus_err_q  <= 1'b0;
            err_code_q <= ERR_NONE;
            err_addr_q <= '0;
        end else begin
            bus_err_q <= err_fire;
            if (err_fire) begin
                err_code_q <= unm_ack ? ERR_UNMAPPED : ERR_TIMEOUT;
                err_addr_q <= g_addr;
            end
            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (req[0] && (!req[1] || last_q)) state_q <= S_GNT0;
                    else if (req[1])                   state_q <= S_GNT1;
                end
                S_GNT0, S_GNT1: begin
                    if (term_ack || abort) begin
                        state_q <= S_IDLE;
                        last_q  <= gnt_idx;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_bus_err  = bus_err_q;
    assign o_err_code = err_code_q;
    assign o_err_addr = err_addr_q;

endmodule

// File: tb/tb_wishbone_arbiter_2m4s.sv
// Directed bench for wishbone_arbiter_2m4s with TIMEOUT = 8; expected values
// are worked out by hand per scenario.
module tb_wishbone_arbiter_2m4s;
    import wb_pkg::*;

    logic                          i_clk;
    logic                          i_rst_n;
    logic [N_MST-1:0][WB_AW-1:0]   i_m_addr;
    logic [N_MST-1:0][WB_DW-1:0]   i_m_data;
    logic [N_MST-1:0]              i_m_we;
    logic [N_MST-1:0]              i_m_stb;
    logic [N_MST-1:0]              i_m_cyc;
    logic [N_MST-1:0][WB_SELW-1:0] i_m_sel;
    logic [N_MST-1:0][WB_DW-1:0]   o_m_data;
    logic [N_MST-1:0]              o_m_ack;
    logic [N_SLV-1:0][WB_AW-1:0]   o_s_addr;
    logic [N_SLV-1:0][WB_DW-1:0]   o_s_data;
    logic [N_SLV-1:0]              o_s_we;
    logic [N_SLV-1:0]              o_s_stb;
    logic [N_SLV-1:0]              o_s_cyc;
    logic [N_SLV-1:0][WB_SELW-1:0] o_s_sel;
    logic [N_SLV-1:0][WB_DW-1:0]   i_s_data;
    logic [N_SLV-1:0]              i_s_ack;
    logic                          o_bus_err;
    logic [1:0]                    o_err_code;
    logic [WB_AW-1:0]              o_err_addr;

    int n_chk = 0;
    int n_err = 0;

    wishbone_arbiter_2m4s #(.TIMEOUT(8), .ERR_DATA(32'h0)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_m_addr   (i_m_addr),
        .i_m_data   (i_m_data),
        .i_m_we     (i_m_we),
        .i_m_stb    (i_m_stb),
        .i_m_cyc    (i_m_cyc),
        .i_m_sel    (i_m_sel),
        .o_m_data   (o_m_data),
        .o_m_ack    (o_m_ack),
        .o_s_addr   (o_s_addr),
        .o_s_data   (o_s_data),
        .o_s_we     (o_s_we),
        .o_s_stb    (o_s_stb),
        .o_s_cyc    (o_s_cyc),
        .o_s_sel    (o_s_sel),
        .i_s_data   (i_s_data),
        .i_s_ack    (i_s_ack),
        .o_bus_err  (o_bus_err),
        .o_err_code (o_err_code),
        .o_err_addr (o_err_addr)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic req(input int m, input logic [31:0] addr, input logic we,
                       input logic [31:0] data, input logic on);
        i_m_addr[m] = addr;
        i_m_we[m]   = we;
        i_m_data[m] = data;
        i_m_sel[m]  = 4'hF;
        i_m_cyc[m]  = on;
        i_m_stb[m]  = on;
    endtask

    initial begin
        logic [1:0] exp_ack;
        i_rst_n  = 1'b0;
        i_m_addr = '0;
        i_m_data = '0;
        i_m_we   = '0;
        i_m_stb  = '0;
        i_m_cyc  = '0;
        i_m_sel  = '0;
        i_s_data = '0;
        i_s_ack  = '0;
        #12;
        check("rst_s_stb", 32'(o_s_stb), 32'h0);
        check("rst_m_ack", 32'(o_m_ack), 32'h0);
        check("rst_err_code", 32'(o_err_code), 32'h0);
        check("rst_err_addr", o_err_addr, 32'h0);
        check("rst_bus_err", 32'(o_bus_err), 32'h0);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // M0 read from slave1, zero-wait ack
        step();
        req(0, 32'h1000_0040, 1'b0, 32'h0, 1'b1);
        @(negedge i_clk);
        check("rd_idle_stb", 32'(o_s_stb), 32'h0);
        step();
        i_s_ack[1]  = 1'b1;
        i_s_data[1] = 32'hCAFE_0001;
        @(negedge i_clk);
        check("rd_s_stb", 32'(o_s_stb), 32'h2);
        check("rd_s_addr", o_s_addr[1], 32'h1000_0040);
        check("rd_m_ack", 32'(o_m_ack), 32'h1);
        check("rd_m_data", o_m_data[0], 32'hCAFE_0001);
        step();
        req(0, 32'h0, 1'b0, 32'h0, 1'b0);
        i_s_ack = '0;
        @(negedge i_clk);
        check("rd_after_stb", 32'(o_s_stb), 32'h0);
        check("rd_after_ack", 32'(o_m_ack), 32'h0);

        // M0 write to slave1: write ack returns zero data
        req(0, 32'h1000_0008, 1'b1, 32'h1234_5678, 1'b1);
        step();
        i_s_ack[1]  = 1'b1;
        i_s_data[1] = 32'hDEAD_BEEF;
        @(negedge i_clk);
        check("wr_s_we", 32'(o_s_we), 32'h2);
        check("wr_s_data", o_s_data[1], 32'h1234_5678);
        check("wr_m_ack", 32'(o_m_ack), 32'h1);
        check("wr_m_data", o_m_data[0], 32'h0);
        step();
        req(0, 32'h0, 1'b0, 32'h0, 1'b0);
        i_s_ack = '0;

        // Continuous contention; M0 was served last, so M1 leads
        req(0, 32'h0000_0000, 1'b0, 32'h0, 1'b1);
        req(1, 32'h0000_0004, 1'b0, 32'h0, 1'b1);
        i_s_data[0] = 32'h0000_00AA;
        exp_ack = 2'b10;
        for (int i = 0; i < 4; i++) begin
            step();
            i_s_ack[0] = 1'b1;
            @(negedge i_clk);
            check($sformatf("rr_ack%0d", i), 32'(o_m_ack), 32'(exp_ack));
            step();
            i_s_ack = '0;
            @(negedge i_clk);
            check($sformatf("rr_idle%0d", i), 32'(o_s_stb), 32'h0);
            exp_ack = {exp_ack[0], exp_ack[1]};
        end
        req(0, 32'h0, 1'b0, 32'h0, 1'b0);
        req(1, 32'h0, 1'b0, 32'h0, 1'b0);

        // M1 unmapped read
        step();
        req(1, 32'hC000_0000, 1'b0, 32'h0, 1'b1);
        step();
        @(negedge i_clk);
        check("unm_ack", 32'(o_m_ack), 32'h2);
        check("unm_data", o_m_data[1], 32'h0);
        check("unm_s_stb", 32'(o_s_stb), 32'h0);
        check("unm_err_pre", 32'(o_bus_err), 32'h0);
        step();
        req(1, 32'h0, 1'b0, 32'h0, 1'b0);
        @(negedge i_clk);
        check("unm_bus_err", 32'(o_bus_err), 32'h1);
        check("unm_code", 32'(o_err_code), 32'h1);
        check("unm_addr", o_err_addr, 32'hC000_0000);
        step();
        @(negedge i_clk);
        check("unm_bus_err_clr", 32'(o_bus_err), 32'h0);

        // M0 to slave2 which never acks: forced ack on grant cycle 8
        req(0, 32'h2000_0010, 1'b0, 32'h0, 1'b1);
        i_s_data[2] = 32'h5555_5555;
        step();
        for (int g = 1; g < 8; g++) begin
            @(negedge i_clk);
            if (g == 1 || g == 7) begin
                check($sformatf("to_wait_ack%0d", g), 32'(o_m_ack), 32'h0);
                check($sformatf("to_wait_stb%0d", g), 32'(o_s_stb), 32'h4);
            end
            step();
        end
        @(negedge i_clk);
        check("to_ack", 32'(o_m_ack), 32'h1);
        check("to_data", o_m_data[0], 32'h0);
        check("to_stb_drop", 32'(o_s_stb), 32'h0);
        step();
        req(0, 32'h0, 1'b0, 32'h0, 1'b0);
        i_s_ack[2] = 1'b1;
        @(negedge i_clk);
        check("to_bus_err", 32'(o_bus_err), 32'h1);
        check("to_code", 32'(o_err_code), 32'h2);
        check("to_addr", o_err_addr, 32'h2000_0010);
        check("to_late_ack", 32'(o_m_ack), 32'h0);
        step();
        i_s_ack = '0;

        // M0 aborts after 3 grant cycles, pending M1 then granted
        req(0, 32'h0000_0100, 1'b0, 32'h0, 1'b1);
        step();
        req(1, 32'h3000_0020, 1'b1, 32'hA5A5_0003, 1'b1);
        @(negedge i_clk);
        check("ab_g1_stb", 32'(o_s_stb), 32'h1);
        step();
        step();
        @(negedge i_clk);
        check("ab_g3_ack", 32'(o_m_ack), 32'h0);
        step();
        i_m_cyc[0] = 1'b0;
        i_m_stb[0] = 1'b0;
        @(negedge i_clk);
        check("ab_drop_stb", 32'(o_s_stb), 32'h0);
        check("ab_drop_ack", 32'(o_m_ack), 32'h0);
        step();
        @(negedge i_clk);
        check("ab_idle_stb", 32'(o_s_stb), 32'h0);
        step();
        @(negedge i_clk);
        check("ab_m1_stb", 32'(o_s_stb), 32'h8);
        check("ab_m1_we", 32'(o_s_we), 32'h8);
        check("ab_m1_data", o_s_data[3], 32'hA5A5_0003);

        // Asynchronous reset in the middle of the M1 write
        req(0, 32'h0000_0100, 1'b0, 32'h0, 1'b1);
        step();
        #2;
        i_rst_n = 1'b0;
        #1;
        check("rst_mid_stb", 32'(o_s_stb), 32'h0);
        check("rst_mid_cyc", 32'(o_s_cyc), 32'h0);
        check("rst_mid_ack", 32'(o_m_ack), 32'h0);
        check("rst_mid_code", 32'(o_err_code), 32'h0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        step();
        @(negedge i_clk);
        check("rst_tie_m0", 32'(o_s_stb), 32'h1);
        req(0, 32'h0, 1'b0, 32'h0, 1'b0);
        req(1, 32'h0, 1'b0, 32'h0, 1'b0);
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
